// File: rtl/usina_pkg.sv
// Shared definitions for the alarm manager: state encoding and default timing.
package usina_pkg;

    // Alarm manager states; the encoding is visible on the estado port.
    typedef enum logic [1:0] {
        ST_NORMAL      = 2'd0,
        ST_ALERTA      = 2'd1,
        ST_RECONHECIDO = 2'd2,
        ST_ESCALADO    = 2'd3
    } estado_t;

    // Default timing, in clock cycles.
    localparam int DEF_DEB_CYC     = 4;
    localparam int DEF_TIMEOUT_CYC = 1000;
    localparam int DEF_BLINK_CYC   = 50;

endpackage

// File: rtl/gerenciador_alarme_filtro.sv
// filtro_alarme: registers the raw alarm level and confirms it only after
// DEB_CYC consecutive sampled-high cycles (dout = alarm_ok).
module filtro_alarme
    import usina_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] DEB_MAX = 4'(DEB_CYC);

    logic       alarme_q;
    logic [3:0] deb_cnt;

    // Input register plus saturating run-length counter of high samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarme_q <= 1'b0;
            deb_cnt  <= 4'd0;
        end else begin
            alarme_q <= din;
            if (!alarme_q) begin
                deb_cnt <= 4'd0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + 4'd1;
            end
        end
    end

    assign dout = (deb_cnt == DEB_MAX);

endmodule

// File: rtl/gerenciador_alarme.sv
// gerenciador_alarme: latches confirmed alarms, drives siren/light, waits for
// operator acknowledge and escalates to a SCRAM request on timeout.
// Optional feature: define ALARM_EVENT_COUNTER_EN to add the 8-bit saturating
// contagem_eventos output counting NORMAL->ALERTA transitions.
module gerenciador_alarme
    import usina_pkg::*;
#(
    parameter int DEB_CYC     = DEF_DEB_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int BLINK_CYC   = DEF_BLINK_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarmeSonoroSC,
    input  logic       ack,
    input  logic       limpar,
    output logic       sirene,
    output logic       luz_alarme,
    output logic       scram,
    output logic [1:0] estado
`ifdef ALARM_EVENT_COUNTER_EN
    ,
    output logic [7:0] contagem_eventos
`endif
);

    localparam logic [15:0] TMR_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_CYC - 1);

    estado_t     state, state_nx;
    logic [15:0] tmr, tmr_nx;
    logic [15:0] blink, blink_nx;
    logic        sirene_nx, luz_nx, scram_nx;
    logic        alarm_ok;
    logic        alarme_q;

    filtro_alarme #(.DEB_CYC(DEB_CYC)) u_filtro (
        .clk  (clk),
        .rst  (rst),
        .din  (alarmeSonoroSC),
        .dout (alarm_ok)
    );

    // Same sample as the filter's input register; gates the operator clear.
    always_ff @(posedge clk) begin
        if (rst) alarme_q <= 1'b0;
        else     alarme_q <= alarmeSonoroSC;
    end

    // Next state, timers and registered-output values.
    always_comb begin
        state_nx  = state;
        tmr_nx    = tmr;
        blink_nx  = blink;
        sirene_nx = 1'b0;

        case (state)
            ST_NORMAL: begin
                if (alarm_ok) state_nx = ST_ALERTA;
            end
            ST_ALERTA: begin
                // ack beats a timeout landing on the same cycle.
                if (ack)                  state_nx = ST_RECONHECIDO;
                else if (tmr == TMR_LAST) state_nx = ST_ESCALADO;
            end
            ST_RECONHECIDO, ST_ESCALADO: begin
                if (limpar && !alarme_q) state_nx = ST_NORMAL;
            end
            default: state_nx = ST_NORMAL;
        endcase

        // Timers restart on every state change and only run in ALERTA.
        if (state_nx != state) begin
            tmr_nx   = 16'd0;
            blink_nx = 16'd0;
        end else if (state == ST_ALERTA) begin
            tmr_nx   = tmr + 16'd1;
            blink_nx = (blink == BLINK_LAST) ? 16'd0 : blink + 16'd1;
        end

        luz_nx   = (state_nx != ST_NORMAL);
        scram_nx = (state_nx == ST_ESCALADO);

        if (state_nx == ST_ESCALADO) begin
            sirene_nx = 1'b1;
        end else if (state_nx == ST_ALERTA) begin
            if (state != ST_ALERTA)       sirene_nx = 1'b1;
            else if (blink == BLINK_LAST) sirene_nx = ~sirene;
            else                          sirene_nx = sirene;
        end
    end

    // State, timers and outputs all update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NORMAL;
            tmr        <= 16'd0;
            blink      <= 16'd0;
            sirene     <= 1'b0;
            luz_alarme <= 1'b0;
            scram      <= 1'b0;
        end else begin
            state      <= state_nx;
            tmr        <= tmr_nx;
            blink      <= blink_nx;
            sirene     <= sirene_nx;
            luz_alarme <= luz_nx;
            scram      <= scram_nx;
        end
    end

    assign estado = state;

`ifdef ALARM_EVENT_COUNTER_EN
    logic [7:0] evt_cnt;

    // Saturating count of alarm episodes; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt <= 8'd0;
        end else if (state == ST_NORMAL && state_nx == ST_ALERTA && evt_cnt != 8'hFF) begin
            evt_cnt <= evt_cnt + 8'd1;
        end
    end

    assign contagem_eventos = evt_cnt;
`endif

endmodule

// File: tb/tb_gerenciador_alarme.sv
// Testbench for gerenciador_alarme (DEB_CYC=4, TIMEOUT_CYC=20, BLINK_CYC=3).
// Directed scenarios with literal expectations, then randomized stimulus
// checked every cycle against a behavioural model.
module tb_gerenciador_alarme;

    localparam int DEB     = 4;
    localparam int TIMEOUT = 20;
    localparam int BLINK   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic ack = 1'b0;
    logic limpar = 1'b0;
    logic sirene, luz_alarme, scram;
    logic [1:0] estado;
`ifdef ALARM_EVENT_COUNTER_EN
    logic [7:0] contagem_eventos;
`endif

    always #5 clk = ~clk;

    gerenciador_alarme #(
        .DEB_CYC     (DEB),
        .TIMEOUT_CYC (TIMEOUT),
        .BLINK_CYC   (BLINK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alarmeSonoroSC (din),
        .ack            (ack),
        .limpar         (limpar),
        .sirene         (sirene),
        .luz_alarme     (luz_alarme),
        .scram          (scram),
        .estado         (estado)
`ifdef ALARM_EVENT_COUNTER_EN
        ,
        .contagem_eventos (contagem_eventos)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist holds the raw input sampled at each edge (most recent last).
    // The operator clear sees the most recent sample; an alarm is confirmed
    // when the DEB samples before the most recent one were all high.
    bit hist[$];
    int m_mode = 0;   // 0 NORMAL, 1 ALERTA, 2 RECONHECIDO, 3 ESCALADO
    int m_c    = 0;   // cycles spent in ALERTA since entry
    int m_evt  = 0;

    always @(posedge clk) begin
        bit ok;
        bit last;
        if (rst) begin
            m_mode = 0;
            m_c    = 0;
            m_evt  = 0;
            hist.delete();
            hist.push_back(1'b0);
        end else begin
            last = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
            ok   = (hist.size() >= DEB + 1);
            if (ok) begin
                for (int i = 0; i < DEB; i++) ok = ok & hist[hist.size()-2-i];
            end
            case (m_mode)
                0: if (ok) begin
                    m_mode = 1;
                    m_c    = 0;
                    if (m_evt < 255) m_evt++;
                end
                1: begin
                    if (ack)                      m_mode = 2;
                    else if (m_c == TIMEOUT - 1)  m_mode = 3;
                    else                          m_c++;
                end
                default: if (limpar && !last) m_mode = 0;
            endcase
            hist.push_back(din);
            if (hist.size() > 40) void'(hist.pop_front());
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_estado", 16'(estado), 16'(m_mode));
            chk("model_luz", 16'(luz_alarme), 16'(m_mode != 0));
            chk("model_scram", 16'(scram), 16'(m_mode == 3));
            chk("model_sirene", 16'(sirene),
                16'((m_mode == 3) || (m_mode == 1 && ((m_c / BLINK) % 2 == 0))));
`ifdef ALARM_EVENT_COUNTER_EN
            chk("model_eventos", 16'(contagem_eventos), 16'(m_evt));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the input high from NORMAL until ALERTA is entered; input stays high.
    task automatic enter_alerta();
        din = 1'b1;
        step(DEB + 1);
        chk("pre_alert_estado", 16'(estado), 16'd0);
        step(1);
        chk("alert_entry_estado", 16'(estado), 16'd1);
    endtask

    task automatic episode();
        enter_alerta();
        ack = 1'b1; step(1); ack = 1'b0;
        din = 1'b0; step(1);
        limpar = 1'b1; step(1); limpar = 1'b0;
    endtask

    logic pat [9];

    initial begin
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // reset
        step(1);
        chk_en = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_estado", 16'(estado), 16'd0);
        chk("rst_sirene", 16'(sirene), 16'd0);
        chk("rst_luz", 16'(luz_alarme), 16'd0);
        chk("rst_scram", 16'(scram), 16'd0);

        // glitch rejection: 3 high cycles
        din = 1'b1; step(3); din = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch_estado", 16'(estado), 16'd0);
            chk("glitch_sirene", 16'(sirene), 16'd0);
        end

        // confirmed alarm and siren blink pattern
        enter_alerta();
        chk("blink_0", 16'(sirene), 16'(pat[0]));
        chk("alert_luz", 16'(luz_alarme), 16'd1);
        for (int i = 1; i < 9; i++) begin
            step(1);
            chk($sformatf("blink_%0d", i), 16'(sirene), 16'(pat[i]));
        end
        step(1);

        // acknowledge, clear refused while input high, then clear
        ack = 1'b1; step(1); ack = 1'b0;
        chk("ack_estado", 16'(estado), 16'd2);
        chk("ack_sirene", 16'(sirene), 16'd0);
        chk("ack_luz", 16'(luz_alarme), 16'd1);
        limpar = 1'b1; step(1); limpar = 1'b0;
        chk("clear_high_estado", 16'(estado), 16'd2);
        din = 1'b0; step(1);
        limpar = 1'b1; step(1); limpar = 1'b0;
        chk("clear_estado", 16'(estado), 16'd0);
        chk("clear_luz", 16'(luz_alarme), 16'd0);

        // escalation after exactly TIMEOUT cycles
        enter_alerta();
        din = 1'b0;
        step(TIMEOUT - 1);
        chk("pre_timeout_estado", 16'(estado), 16'd1);
        step(1);
        chk("esc_estado", 16'(estado), 16'd3);
        chk("esc_scram", 16'(scram), 16'd1);
        chk("esc_sirene", 16'(sirene), 16'd1);
        ack = 1'b1; step(2); ack = 1'b0;
        chk("esc_ack_ignored", 16'(estado), 16'd3);
        limpar = 1'b1; step(1); limpar = 1'b0;
        chk("esc_clear_estado", 16'(estado), 16'd0);
        chk("esc_clear_scram", 16'(scram), 16'd0);

        // ack on the timeout cycle wins
        enter_alerta();
        din = 1'b0;
        step(TIMEOUT - 1);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("ack_timeout_estado", 16'(estado), 16'd2);
        chk("ack_timeout_scram", 16'(scram), 16'd0);
        limpar = 1'b1; step(1); limpar = 1'b0;
        chk("ack_timeout_clear", 16'(estado), 16'd0);

        // reset from ESCALADO
        enter_alerta();
        step(TIMEOUT);
        chk("rst_pre_estado", 16'(estado), 16'd3);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rst_esc_estado", 16'(estado), 16'd0);
        chk("rst_esc_sirene", 16'(sirene), 16'd0);
        chk("rst_esc_luz", 16'(luz_alarme), 16'd0);
        chk("rst_esc_scram", 16'(scram), 16'd0);
        din = 1'b0;
        step(2);

`ifdef ALARM_EVENT_COUNTER_EN
        rst = 1'b1; step(1); rst = 1'b0;
        for (int i = 0; i < 3; i++) episode();
        chk("evt_3", 16'(contagem_eventos), 16'd3);
        for (int i = 0; i < 297; i++) episode();
        chk("evt_sat", 16'(contagem_eventos), 16'd255);
`else
        episode();
`endif

        // randomized stimulus, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) din = ~din;
            ack    = ($urandom_range(0, 15) == 0);
            limpar = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0; ack = 1'b0; limpar = 1'b0;
        step(2);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gerenciador_alarme.md
Name: gerenciador_alarme

Overview:
- Sequential alarm manager directly downstream of the control-room alarm logic.
- Consumes the raw combinational alarm level from the control room (temperature/pressure/radiation OR) and filters out glitches.
- Latches each confirmed alarm and drives the siren and panel light from that latch.
- Requires operator acknowledge; escalates to a SCRAM (reactor trip) request if the alarm goes unacknowledged for too long.

Parameters:
- DEB_CYC, 4: consecutive sampled-high cycles required to confirm an alarm (1..15).
- TIMEOUT_CYC, 1000: cycles allowed in ALERTA without acknowledge before escalation (2..65535).
- BLINK_CYC, 50: siren half-period in ALERTA, in cycles (1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- alarmeSonoroSC  in  1  raw alarm level from the control room
- ack  in  1  operator acknowledge (level, sampled each cycle)
- limpar  in  1  operator clear request
- sirene  out  1  siren drive
- luz_alarme  out  1  panel alarm light
- scram  out  1  reactor trip request
- estado  out  2  current state: 0 NORMAL, 1 ALERTA, 2 RECONHECIDO, 3 ESCALADO

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: rst high at an edge puts the block in NORMAL and clears all counters. The next cycle sirene=0, luz_alarme=0, scram=0, estado=0. rst overrides every other input, including mid-ALERTA and mid-ESCALADO.
- Input register: alarmeSonoroSC goes through one input register to give alarme_q.
- Debounce counter (deb_cnt, 4 bits):
  - alarme_q=1: increments, saturating at DEB_CYC.
  - alarme_q=0: clears to 0.
  - alarm_ok = (deb_cnt == DEB_CYC).
- Alarm latency: if alarmeSonoroSC is first high at edge k and stays high, alarm_ok=1 after edge k+DEB_CYC and estado=ALERTA after edge k+DEB_CYC+1. A pulse shorter than DEB_CYC cycles never leaves NORMAL.
- State timer tmr (16 bits): clears on every state entry, increments each cycle in ALERTA.
- Outputs are registered and change on the same edge as estado.
- NORMAL: all outputs 0. alarm_ok -> ALERTA.
- ALERTA:
  - luz_alarme=1.
  - sirene=1 on entry, then toggles every BLINK_CYC cycles.
  - ack=1 -> RECONHECIDO.
  - Otherwise tmr==TIMEOUT_CYC-1 -> ESCALADO, i.e. escalation after exactly TIMEOUT_CYC cycles in ALERTA.
  - The alarm clearing at the input does NOT leave ALERTA; the alarm is latched until acknowledged.
  - ack and timeout on the same cycle: ack wins.
- RECONHECIDO:
  - sirene=0, luz_alarme=1.
  - limpar=1 with alarme_q=0 -> NORMAL.
  - limpar while alarme_q=1 is ignored.
  - A new alarm_ok edge does not re-enter ALERTA.
- ESCALADO:
  - scram=1, sirene=1 steady, luz_alarme=1.
  - ack is ignored.
  - Exit only by limpar=1 with alarme_q=0 (-> NORMAL) or by rst.
- Exiting to NORMAL clears deb_cnt's influence: a still-high input must satisfy a full DEB_CYC again.

Optional Feature:
- Macro: ALARM_EVENT_COUNTER_EN.
- Defined:
  - Adds output port contagem_eventos (out, 8 bits).
  - Increments on each NORMAL->ALERTA transition and saturates at 255.
  - Cleared only by rst.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package usina_pkg:
  - state encoding constants ST_NORMAL=2'd0, ST_ALERTA=2'd1, ST_RECONHECIDO=2'd2, ST_ESCALADO=2'd3
  - default timing constants
- Sub-module filtro_alarme:
  - contains the input register and the debounce counter
  - parameter DEB_CYC
  - ports clk, rst, din, dout (dout = alarm_ok)
- The FSM, timer and siren toggle stay in gerenciador_alarme.

Test Plan (bench parameters DEB_CYC=4, TIMEOUT_CYC=20, BLINK_CYC=3):
- Glitch rejection: alarmeSonoroSC high for 3 cycles, then low -> estado stays 0; sirene, luz_alarme and scram stay 0 throughout.
- Confirmed alarm: alarmeSonoroSC held high from edge k -> estado=1 after edge k+5; sirene=1 for 3 cycles, 0 for 3, 1 for 3.
- Acknowledge and clear:
  - ack=1 at cycle 10 of ALERTA -> estado=2, sirene=0, luz_alarme=1.
  - limpar with input still high -> stays 2.
  - Drop input, wait 1 cycle, then limpar -> estado=0.
- Escalation:
  - No ack -> estado=3 and scram=1 exactly 20 cycles after entering ALERTA.
  - ack in ESCALADO -> no change.
  - limpar with input low -> estado=0, scram=0.
- Simultaneous events and reset:
  - ack asserted on the timeout cycle (tmr=19) -> estado=2 and scram stays 0.
  - rst in ESCALADO -> next cycle all outputs 0, estado=0.
- ALARM_EVENT_COUNTER_EN:
  - 3 confirmed alarm episodes -> contagem_eventos=3.
  - 300 episodes -> contagem_eventos=255.
